// File: rtl/alu_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// alu_arbiter_pkg
// Purpose : Shared definitions for the ALU arbiter slice.
//   - WORD_SIZE / ALU_OPSIZE: datapath and opcode widths used by the ALU.
//   - Opcode encodings understood by the ALU. Any other code yields 0.
//   - arb_state_t: arbiter FSM states (IDLE, EXEC, RESP).
//   - NUM_REQ_DEFAULT: default number of requesters sharing the ALU.
// -----------------------------------------------------------------------------
package alu_arbiter_pkg;

  localparam int WORD_SIZE       = 32;
  localparam int ALU_OPSIZE      = 4;
  localparam int NUM_REQ_DEFAULT = 2;

  localparam logic [ALU_OPSIZE-1:0] OP_ADD  = 4'd0;
  localparam logic [ALU_OPSIZE-1:0] OP_SUB  = 4'd1;
  localparam logic [ALU_OPSIZE-1:0] OP_AND  = 4'd2;
  localparam logic [ALU_OPSIZE-1:0] OP_OR   = 4'd3;
  localparam logic [ALU_OPSIZE-1:0] OP_XOR  = 4'd4;
  localparam logic [ALU_OPSIZE-1:0] OP_SLL  = 4'd5;
  localparam logic [ALU_OPSIZE-1:0] OP_SRL  = 4'd6;
  localparam logic [ALU_OPSIZE-1:0] OP_SRA  = 4'd7;
  localparam logic [ALU_OPSIZE-1:0] OP_SLT  = 4'd8;
  localparam logic [ALU_OPSIZE-1:0] OP_SLTU = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

endpackage : alu_arbiter_pkg

// File: rtl/alu_arbiter_alu.sv
// -----------------------------------------------------------------------------
// alu_arbiter_alu
// Purpose : Purely combinational ALU shared by all requesters.
// Ports   :
//   i_op     [ALU_OPSIZE-1:0]  opcode (see alu_arbiter_pkg)
//   i_a      [WORD_SIZE-1:0]   operand A
//   i_b      [WORD_SIZE-1:0]   operand B (full width is the shift amount)
//   o_result [WORD_SIZE-1:0]   result, no carry/flags; unknown opcode -> 0
// -----------------------------------------------------------------------------
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  logic [ALU_OPSIZE-1:0] i_op,
  input  logic [WORD_SIZE-1:0]  i_a,
  input  logic [WORD_SIZE-1:0]  i_b,
  output logic [WORD_SIZE-1:0]  o_result
);

  logic [WORD_SIZE-1:0] w_result;

  always_comb begin
    w_result = '0;
    case (i_op)
      OP_ADD:  w_result = i_a + i_b;
      OP_SUB:  w_result = i_a - i_b;
      OP_AND:  w_result = i_a & i_b;
      OP_OR:   w_result = i_a | i_b;
      OP_XOR:  w_result = i_a ^ i_b;
      // Shifts use the whole of B: amounts >= WORD_SIZE flush the word
      // (zero for logical shifts, sign fill for the arithmetic one).
      OP_SLL:  w_result = i_a << i_b;
      OP_SRL:  w_result = i_a >> i_b;
      OP_SRA:  w_result = $signed(i_a) >>> i_b;
      OP_SLT:  w_result[0] = ($signed(i_a) < $signed(i_b));
      OP_SLTU: w_result[0] = (i_a < i_b);
      default: w_result = '0;
    endcase
  end

  assign o_result = w_result;

endmodule : alu_arbiter_alu

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Purpose : Round-robin arbiter sharing one ALU between NUM_REQ requesters.
//           One operation at a time: IDLE (grant) -> EXEC (compute) ->
//           RESP (hold result until the granted requester accepts).
// Ports   :
//   i_clk, i_rst_n               clock, async active-low reset
//   i_req_valid  [NUM_REQ]       per-requester request
//   o_req_ready  [NUM_REQ]       grant, one-hot or zero, only in IDLE
//   i_req_op     [NUM_REQ][OP]   per-requester opcode
//   i_req_a/b    [NUM_REQ][W]    per-requester operands
//   o_rsp_valid  [NUM_REQ]       result valid for the granted requester
//   i_rsp_ready  [NUM_REQ]       result accept (only winner's bit used)
//   o_rsp_result [W]             shared result bus
//   o_busy                       high whenever not IDLE
// -----------------------------------------------------------------------------
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic [NUM_REQ-1:0]                   i_req_valid,
  output logic [NUM_REQ-1:0]                   o_req_ready,
  input  logic [NUM_REQ-1:0][ALU_OPSIZE-1:0]   i_req_op,
  input  logic [NUM_REQ-1:0][WORD_SIZE-1:0]    i_req_a,
  input  logic [NUM_REQ-1:0][WORD_SIZE-1:0]    i_req_b,
  output logic [NUM_REQ-1:0]                   o_rsp_valid,
  input  logic [NUM_REQ-1:0]                   i_rsp_ready,
  output logic [WORD_SIZE-1:0]                 o_rsp_result,
  output logic                                 o_busy
);

  localparam int IDX_W = (NUM_REQ > 2) ? 2 : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  // Returns {found, index}: first set bit of i_valid searching upward from
  // i_ptr with wrap. Scanning from the farthest offset down lets the
  // nearest candidate overwrite earlier hits, so the loop has no early exit.
  function automatic logic [IDX_W:0] rr_pick(
    input logic [NUM_REQ-1:0] i_valid,
    input logic [IDX_W-1:0]   i_ptr
  );
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;
    logic [IDX_W:0]   res;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, i_ptr} + (IDX_W + 1)'(k);
      if (sum >= (IDX_W + 1)'(NUM_REQ)) begin
        sum = sum - (IDX_W + 1)'(NUM_REQ);
      end
      cand = sum[IDX_W-1:0];
      if (i_valid[cand]) begin
        res = {1'b1, cand};
      end
    end
    return res;
  endfunction

  arb_state_t             r_state;
  arb_state_t             w_state_next;
  logic [IDX_W-1:0]       r_ptr;
  logic [IDX_W-1:0]       r_winner;
  logic [ALU_OPSIZE-1:0]  r_op;
  logic [WORD_SIZE-1:0]   r_a;
  logic [WORD_SIZE-1:0]   r_b;
  logic [WORD_SIZE-1:0]   r_result;
  logic [WORD_SIZE-1:0]   w_alu_result;

  logic                   w_grant_found;
  logic [IDX_W-1:0]       w_grant_idx;
  logic                   w_handshake;
  logic                   w_ready_en;
  logic                   w_rsp_en;

  assign {w_grant_found, w_grant_idx} = rr_pick(i_req_valid, r_ptr);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_handshake  = 1'b0;
    w_ready_en   = 1'b0;
    w_rsp_en     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready_en = 1'b1;
        // Ready is only offered to a valid winner, so a found winner is a
        // completed handshake this cycle.
        if (w_grant_found) begin
          w_handshake  = 1'b1;
          w_state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_state_next = ST_RESP;
      end
      ST_RESP: begin
        w_rsp_en = 1'b1;
        if (i_rsp_ready[r_winner]) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Captured request, round-robin pointer and result
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr    <= '0;
      r_winner <= '0;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
    end else begin
      if (w_handshake) begin
        r_winner <= w_grant_idx;
        r_op     <= i_req_op[w_grant_idx];
        r_a      <= i_req_a[w_grant_idx];
        r_b      <= i_req_b[w_grant_idx];
        r_ptr    <= (w_grant_idx == LAST_IDX) ? '0 : w_grant_idx + IDX_W'(1);
      end
      if (r_state == ST_EXEC) begin
        r_result <= w_alu_result;
      end
    end
  end

  alu_arbiter_alu u_alu (
    .i_op     (r_op),
    .i_a      (r_a),
    .i_b      (r_b),
    .o_result (w_alu_result)
  );

  // ---------------------------------------------------------------------------
  // Per-requester handshake outputs
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      // Reset already forces IDLE, but IDLE offers ready combinationally, so
      // the reset level itself must also mask the grant while asserted.
      assign o_req_ready[gi] = i_rst_n & w_ready_en & w_grant_found
                               & (w_grant_idx == IDX_W'(gi));
      assign o_rsp_valid[gi] = w_rsp_en & (r_winner == IDX_W'(gi));
    end
  endgenerate

  assign o_rsp_result = r_result;
  assign o_busy       = (r_state != ST_IDLE);

endmodule : alu_arbiter

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2, number of requesters sharing the ALU; legal range 2..4.
REQ-002 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 i_rst_n  input  1  reset; one clock, asynchronous assert, active-low.
REQ-004 i_req_valid  input  NUM_REQ  per-requester operation request.
REQ-005 o_req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
REQ-006 i_req_op  input  NUM_REQ x ALU_OPSIZE  per-requester ALU opcode.
REQ-007 i_req_a  input  NUM_REQ x WORD_SIZE  per-requester operand A.
REQ-008 i_req_b  input  NUM_REQ x WORD_SIZE  per-requester operand B.
REQ-009 o_rsp_valid  output  NUM_REQ  per-requester result valid; one-hot or zero.
REQ-010 i_rsp_ready  input  NUM_REQ  per-requester result accept.
REQ-011 o_rsp_result  output  WORD_SIZE  shared result bus, meaningful only where o_rsp_valid set.
REQ-012 o_busy  output  1  high whenever state is not IDLE.

Function
REQ-013 FSM states: IDLE, EXEC, RESP; exactly one active.
REQ-014 IDLE: o_req_ready asserted combinationally for the round-robin winner among set i_req_valid bits only; zero if none valid.
REQ-015 Round-robin: search starts at index ptr, wraps modulo NUM_REQ; first valid index wins.
REQ-016 Request handshake (valid & ready same cycle): op, A, B and winner index registered; ptr <= winner+1 mod NUM_REQ; IDLE -> EXEC.
REQ-017 EXEC: single ALU instance evaluates registered op/A/B; result registered; EXEC -> RESP unconditionally; o_req_ready all zero.
REQ-018 RESP: o_rsp_valid[winner]=1, o_rsp_result = registered result, held stable until i_rsp_ready[winner]=1; then RESP -> IDLE.
REQ-019 i_rsp_ready bits of non-winning requesters ignored.
REQ-020 Latency: request handshake in cycle N -> o_rsp_valid high in cycle N+2; minimum 3 cycles per operation (no overlap).
REQ-021 o_req_ready zero in EXEC and RESP; requests held pending, no loss.
REQ-022 Requester deasserting i_req_valid before handshake: no grant, ptr unchanged.
REQ-023 Undefined opcode: result 0, normal handshake.
REQ-024 Widths: result full WORD_SIZE, no carry/flag outputs; shift amount taken as full operand B per ALU semantics.
REQ-025 Simultaneous response accept and new request: new request not granted until IDLE next cycle.

Reset
REQ-026 i_rst_n low at any time, including mid-EXEC or mid-RESP: state IDLE, ptr 0, o_rsp_valid 0, o_req_ready 0 while asserted, o_busy 0, registered op/A/B/result 0; in-flight operation discarded.
REQ-027 First cycle after release: normal IDLE arbitration, requester 0 highest priority.

Structure
REQ-028 State enum (IDLE, EXEC, RESP) and NUM_REQ default in shared package alu_arbiter_pkg; WORD_SIZE, ALU_OPSIZE and opcode encodings from existing shared defaults.
REQ-029 Exactly one sub-module: existing alu instance fed by registered op/A/B.
REQ-030 Round-robin winner computed in one combinational function; no latches.

Verification
REQ-031 Single op: req0 ADD A=5 B=7 -> ready0 same cycle, rsp_valid0 two cycles later, result 12.
REQ-032 Contention: req0 and req1 valid from reset, each SUB 10-3 -> grant order 0,1,0,1; both see result 7.
REQ-033 Backpressure: rsp_ready0 low 5 cycles -> rsp_valid0 and result held stable, req_ready zero throughout.
REQ-034 Reset mid-EXEC: drop i_rst_n during EXEC -> all outputs 0 immediately, next op from req1 only granted after release.
REQ-035 Wrong-ready: in RESP for req1, assert rsp_ready0 only -> stays RESP, rsp_valid1 held.
REQ-036 SRA 0x80000000 by 4 via req1 -> result 0xF8000000; undefined opcode -> result 0.
